sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
// PURPOSE
//   Serial-in/parallel-out stage downstream of the DFF bit register: takes the
//   registered serial bit (DFF Q) one bit per enabled Clk edge and assembles
//   WIDTH-bit words. It presents each word on Q with done and holds it until
//   the consumer acks. It detects and flags overrun while shifting continues.
// PARAMETERS
//   WIDTH      8   word length in bits (>=2)
//   MSB_FIRST  1   1: first received bit lands in Q[WIDTH-1]; 0: first bit lands in Q[0]
// PORTS
//   Clk      input   1                       single clock, rising edge
//   Rst      input   1                       synchronous reset, active-high
//   D        input   1                       serial data bit (from upstream DFF Q)
//   En       input   1                       D valid this edge; 0 = gap, nothing sampled
//   Ack      input   1                       consumer accepts current word (done=1)
//   Q        output  WIDTH                   assembled word, registered
//   done     output  1                       Q holds an unconsumed word
//   Overrun  output  1                       sticky: a completed word was dropped
//   BitCnt   output  $clog2(WIDTH)           bits collected in the current word
// BEHAVIOUR
//   - Reset (Rst=1 at edge): Q=0, done=0, Overrun=0, BitCnt=0, shift reg=0.
//     Reset beats En/Ack. Reset mid-word discards the partial bits.
//   - En=1: shift D into sh and increment BitCnt. En=0: all state holds.
//     Gaps of any length are legal.
//   - Completion: an edge with En=1 and BitCnt==WIDTH-1. The word {sh,D}
//     (MSB_FIRST) or {D,sh} (LSB-first order) is ready and BitCnt wraps to 0 on
//     the same edge. Q/done update on that same edge; latency is 0 cycles after
//     the last bit is sampled.
//   - FSM for the output side:
//       EMPTY (done=0) --completion--> FULL (Q<=word, done<=1)
//       FULL --Ack, no completion-->   EMPTY (done<=0; Q keeps its last value)
//       FULL --Ack + completion-->     FULL (Q<=new word; no overrun)
//       FULL --completion, no Ack-->   FULL (new word dropped, Q unchanged,
//                                      Overrun<=1)
//   - Ack while EMPTY is ignored. Ack is sampled only at edges, so a 1-cycle
//     pulse is sufficient.
//   - Overrun clears only on Rst.
//   - Shifting never stalls. The input side is independent of done.
//   - All outputs are registered. There is no combinational path from an
//     input to an output.
// STRUCTURE
//   - Shared include: WIDTH default, and state encodings ST_EMPTY=1'b0 and
//     ST_FULL=1'b1.
//   - One natural sub-module: sipo_shift_core. It holds the shift register,
//     BitCnt and the completion pulse (params WIDTH, MSB_FIRST). The top holds
//     the EMPTY/FULL FSM, the Q register and Overrun.
// TESTING (WIDTH=8 unless stated; Clk period 30, as in DFF bench)
//   1. Rst 2 edges, then En=1 with bits 1,0,1,1,0,0,1,0
//      -> after the 8th edge: Q=8'hB2, done=1, Overrun=0, BitCnt=0.
//   2. Hold Ack=0 for 3 edges -> Q stays 8'hB2, done=1.
//      Then pulse Ack for 1 edge -> done=0 and Q stays 8'hB2.
//   3. Feed 8'hFF with En toggling 1,0,1,0,...
//      -> done rises only on the 8th enabled edge; BitCnt steps only on En=1.
//   4. Leave 8'hB2 unacked, then feed a full second word 8'h11
//      -> Overrun=1, Q=8'hB2, done=1. Overrun persists after Ack.
//   5. Keep done=1 and assert Ack on the same edge that completes 8'h5A
//      -> Q=8'h5A, done=1, Overrun unchanged (0 after Rst).
//   6. Assert Rst after 5 bits -> all outputs 0. Then feed 8'h3C -> Q=8'h3C.
//      With MSB_FIRST=0, bits 1,0,1,1,0,0,1,0 -> Q=8'h4D.

Source files
------------

// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer: default
// word length and the output-side state encoding.
package sipo_deserializer_pkg;

  localparam int SIPO_WIDTH_DEFAULT = 8;

  // Output side holds at most one word awaiting the consumer.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage : sipo_deserializer_pkg

// File: rtl/sipo_shift_core.sv
// Input side of the deserializer: shifts one serial bit per enabled edge,
// counts bits in the current word and flags the edge that completes a word.
// The completion flag and assembled word are combinational from the current
// state and inputs so the parent can capture the word on that very edge.
module sipo_shift_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             d_i,
  input  logic             en_i,
  output logic             complete_o,
  output logic [WIDTH-1:0] word_o,
  output logic [CW-1:0]    bit_cnt_o
);

  // Only WIDTH-1 prior bits need storing; the final bit comes straight from d_i.
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word;
  logic             last_bit;

  // Next-state for the shift register and bit counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    last_bit = (cnt_q == CW'(WIDTH - 1));
    if (MSB_FIRST) begin
      word = {sh_q, d_i};
      if (en_i) sh_d = word[WIDTH-2:0];
    end else begin
      word = {d_i, sh_q};
      if (en_i) sh_d = word[WIDTH-1:1];
    end
    if (en_i) begin
      cnt_d = last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  // Shift register and counter; a gap (en_i=0) holds everything.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign complete_o = en_i && last_bit;
  assign word_o     = word;
  assign bit_cnt_o  = cnt_q;

endmodule : sipo_shift_core

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer. The shift core assembles words from
// the serial stream; this level presents each word on Q with done, holds it
// until Ack, and raises a sticky Overrun when a completed word is dropped.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             D,
  input  logic             En,
  input  logic             Ack,
  output logic [WIDTH-1:0] Q,
  output logic             done,
  output logic             Overrun,
  output logic [CW-1:0]    BitCnt
);

  logic             complete;
  logic [WIDTH-1:0] word;

  out_state_e       state_q;
  logic [WIDTH-1:0] q_q;
  logic             done_q;
  logic             overrun_q;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_core (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .d_i        (D),
    .en_i       (En),
    .complete_o (complete),
    .word_o     (word),
    .bit_cnt_o  (BitCnt)
  );

  // Output-side FSM with registered Q, done and Overrun; reset wins over all.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_EMPTY;
      q_q       <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          // Ack with nothing held is ignored.
          if (complete) begin
            q_q     <= word;
            done_q  <= 1'b1;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (complete && Ack) begin
            // Consumer frees the slot on the same edge a new word lands.
            q_q <= word;
          end else if (complete) begin
            // Held word still unconsumed: the new one is lost.
            overrun_q <= 1'b1;
          end else if (Ack) begin
            // Q keeps its last value; only done drops.
            done_q  <= 1'b0;
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign Q       = q_q;
  assign done    = done_q;
  assign Overrun = overrun_q;

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer. Stimulus pushes each word that
// should be presented into a scoreboard queue; a monitor pops and compares
// whenever the DUT presents a new word (done rises, or Q changes while done).
module tb_sipo_deserializer;

  localparam int W = 8;

  logic         Clk;
  // MSB-first instance
  logic         Rst, D, En, Ack;
  logic [W-1:0] Q;
  logic         done, Overrun;
  logic [2:0]   BitCnt;
  // LSB-first instance
  logic         Rst_l, D_l, En_l, Ack_l;
  logic [W-1:0] Q_l;
  logic         done_l, Overrun_l;
  logic [2:0]   BitCnt_l;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_l[$];

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .D(D), .En(En), .Ack(Ack),
    .Q(Q), .done(done), .Overrun(Overrun), .BitCnt(BitCnt)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .Clk(Clk), .Rst(Rst_l), .D(D_l), .En(En_l), .Ack(Ack_l),
    .Q(Q_l), .done(done_l), .Overrun(Overrun_l), .BitCnt(BitCnt_l)
  );

  initial begin
    Clk = 1'b0;
    forever #15 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      D  = w[i];
      En = 1'b1;
      step();
    end
    En = 1'b0;
  endtask

  task automatic pulse_ack();
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  // Scoreboard monitor, MSB-first instance.
  logic         prev_done = 1'b0;
  logic [W-1:0] prev_q    = '0;
  logic [W-1:0] mon_w;
  always @(posedge Clk) begin
    #2;
    if (done === 1'b1 && (prev_done !== 1'b1 || Q !== prev_q)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_msb unexpected word got=%0h", Q);
      end else begin
        mon_w = exp_q.pop_front();
        check("mon_msb_word", 32'(Q), 32'(mon_w));
      end
    end
    prev_done = done;
    prev_q    = Q;
  end

  // Scoreboard monitor, LSB-first instance.
  logic         prev_done_l = 1'b0;
  logic [W-1:0] prev_q_l    = '0;
  logic [W-1:0] mon_wl;
  always @(posedge Clk) begin
    #2;
    if (done_l === 1'b1 && (prev_done_l !== 1'b1 || Q_l !== prev_q_l)) begin
      if (exp_l.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_lsb unexpected word got=%0h", Q_l);
      end else begin
        mon_wl = exp_l.pop_front();
        check("mon_lsb_word", 32'(Q_l), 32'(mon_wl));
      end
    end
    prev_done_l = done_l;
    prev_q_l    = Q_l;
  end

  initial begin
    logic [W-1:0] lsb_bits;
    Rst = 1'b1; D = 1'b0; En = 1'b0; Ack = 1'b0;
    Rst_l = 1'b1; D_l = 1'b0; En_l = 1'b0; Ack_l = 1'b0;

    // 1. Reset then first word 1,0,1,1,0,0,1,0
    step();
    step();
    Rst = 1'b0; Rst_l = 1'b0;
    check("rst_q", 32'(Q), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_overrun", 32'(Overrun), 32'h0);
    check("rst_bitcnt", 32'(BitCnt), 32'h0);
    exp_q.push_back(8'hB2);
    send_word(8'hB2);
    check("t1_q", 32'(Q), 32'hB2);
    check("t1_done", 32'(done), 32'h1);
    check("t1_overrun", 32'(Overrun), 32'h0);
    check("t1_bitcnt", 32'(BitCnt), 32'h0);

    // 2. Hold without Ack, then a one-edge Ack pulse
    step(); step(); step();
    check("t2_hold_q", 32'(Q), 32'hB2);
    check("t2_hold_done", 32'(done), 32'h1);
    pulse_ack();
    check("t2_ack_done", 32'(done), 32'h0);
    check("t2_ack_q", 32'(Q), 32'hB2);

    // 3. 8'hFF with En toggling; BitCnt moves only on enabled edges
    exp_q.push_back(8'hFF);
    for (int i = 0; i < W; i++) begin
      D = 1'b1; En = 1'b1;
      step();
      check("t3_cnt_en", 32'(BitCnt), 32'((i + 1) % W));
      check("t3_done_en", 32'(done), 32'(i == W - 1));
      En = 1'b0;
      step();
      check("t3_cnt_gap", 32'(BitCnt), 32'((i + 1) % W));
    end
    check("t3_q", 32'(Q), 32'hFF);
    pulse_ack();
    check("t3_ack_done", 32'(done), 32'h0);

    // 4. Unacked 8'hB2, then 8'h11 arrives and is dropped
    exp_q.push_back(8'hB2);
    send_word(8'hB2);
    send_word(8'h11);
    check("t4_overrun", 32'(Overrun), 32'h1);
    check("t4_q", 32'(Q), 32'hB2);
    check("t4_done", 32'(done), 32'h1);
    pulse_ack();
    check("t4_overrun_sticky", 32'(Overrun), 32'h1);
    check("t4_ack_done", 32'(done), 32'h0);

    // 5. Ack on the edge that completes 8'h5A while a word is held
    Rst = 1'b1; step(); Rst = 1'b0;
    check("t5_rst_overrun", 32'(Overrun), 32'h0);
    exp_q.push_back(8'h11);
    send_word(8'h11);
    exp_q.push_back(8'h5A);
    for (int i = W - 1; i >= 0; i--) begin
      D = 1'(8'h5A >> i); En = 1'b1;
      Ack = (i == 0);
      step();
    end
    En = 1'b0; Ack = 1'b0;
    check("t5_q", 32'(Q), 32'h5A);
    check("t5_done", 32'(done), 32'h1);
    check("t5_overrun", 32'(Overrun), 32'h0);

    // 6. Reset mid-word discards partial bits, then 8'h3C
    for (int i = 0; i < 5; i++) begin
      D = 1'b1; En = 1'b1;
      step();
    end
    En = 1'b0;
    check("t6_partial_cnt", 32'(BitCnt), 32'h5);
    Rst = 1'b1; step(); Rst = 1'b0;
    check("t6_rst_q", 32'(Q), 32'h0);
    check("t6_rst_done", 32'(done), 32'h0);
    check("t6_rst_overrun", 32'(Overrun), 32'h0);
    check("t6_rst_cnt", 32'(BitCnt), 32'h0);
    exp_q.push_back(8'h3C);
    send_word(8'h3C);
    check("t6_q", 32'(Q), 32'h3C);
    check("t6_done", 32'(done), 32'h1);

    // LSB-first: bits 1,0,1,1,0,0,1,0 in arrival order -> 8'h4D
    lsb_bits = 8'b1011_0010;
    exp_l.push_back(8'h4D);
    for (int i = W - 1; i >= 0; i--) begin
      D_l = lsb_bits[i]; En_l = 1'b1;
      step();
    end
    En_l = 1'b0;
    check("lsb_q", 32'(Q_l), 32'h4D);
    check("lsb_done", 32'(done_l), 32'h1);

    step(); step();
    check("sb_msb_drained", 32'(exp_q.size()), 32'h0);
    check("sb_lsb_drained", 32'(exp_l.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sipo_deserializer
